// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiply FSM states,
// bus widths and the decoded ID->EXE bus layout.
package exe_pkg;

  localparam int ID_EXE_W  = 144;
  localparam int EXE_MEM_W = 106;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_XOR  = 4'h6;
  localparam logic [3:0] ALU_NOR  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  mul_op;
    logic [3:0]  alu_op;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
  } id_exe_t;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 when read unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_iter.sv
// Radix-2 shift-add multiplier: 32 steps over operand magnitudes, sign fixed
// up on the final product. Operands are captured on start.
module mult_iter
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_BUSY;
          count_d  = 5'd0;
          mcand_d  = {32'd0, mag32(a, is_signed)};
          mplier_d = mag32(b, is_signed);
          acc_d    = 64'd0;
          neg_d    = is_signed & (a[31] ^ b[31]);
        end
      end
      MUL_BUSY: begin
        if (abort) begin
          state_d = MUL_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = {mcand_q[62:0], 1'b0};
          mplier_d = {1'b0, mplier_q[31:1]};
          count_d  = count_q + 5'd1;
          if (count_q == 5'd31) state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MUL_IDLE;
      count_q  <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  assign done    = (state_q == MUL_DONE);
  assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule

// File: rtl/exe_iter.sv
// Execute stage: single-cycle ALU, bus pack/unpack and HI/LO registers.
// Define EXE_MULT_EN to build in the iterative multiplier; otherwise hi/lo are 0.
module exe_iter
  import exe_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 EXE_valid,
  input  logic [ID_EXE_W-1:0]  ID_EXE_bus_r,
  output logic                 EXE_over,
  output logic [EXE_MEM_W-1:0] EXE_MEM_bus,
  output logic [31:0]          EXE_pc,
  output logic [31:0]          hi,
  output logic [31:0]          lo
);

  id_exe_t     id;
  logic [31:0] op1, op2;
  logic [31:0] alu_result;
  logic [31:0] exe_result;

  assign id  = ID_EXE_bus_r;
  assign op1 = id.alu_operand1;
  assign op2 = id.alu_operand2;

  always_comb begin
    alu_result = 32'd0;
    case (id.alu_op)
      ALU_ADD:  alu_result = op1 + op2;
      ALU_SUB:  alu_result = op1 - op2;
      ALU_SLT:  alu_result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_result = {31'd0, op1 < op2};
      ALU_AND:  alu_result = op1 & op2;
      ALU_OR:   alu_result = op1 | op2;
      ALU_XOR:  alu_result = op1 ^ op2;
      ALU_NOR:  alu_result = ~(op1 | op2);
      ALU_SLL:  alu_result = op2 << op1[4:0];
      ALU_SRL:  alu_result = op2 >> op1[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(op2) >>> op1[4:0]);
      ALU_LUI:  alu_result = {op2[15:0], 16'd0};
      default:  alu_result = 32'd0;
    endcase
  end

`ifdef EXE_MULT_EN
  logic        mul_start, mul_abort, mul_done;
  logic [63:0] mul_product;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  assign mul_start = EXE_valid & id.mul_op[1];
  assign mul_abort = ~EXE_valid;

  mult_iter u_mult (
    .clk       (clk),
    .resetn    (resetn),
    .start     (mul_start),
    .abort     (mul_abort),
    .is_signed (id.mul_op[0]),
    .a         (op1),
    .b         (op2),
    .done      (mul_done),
    .product   (mul_product)
  );

  // HI/LO only take the product on the edge that closes a DONE cycle still held valid.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_done && EXE_valid) {hi_d, lo_d} = mul_product;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign exe_result = id.mul_op[1] ? mul_product[31:0] : alu_result;
  assign EXE_over   = EXE_valid & (~id.mul_op[1] | mul_done);
  assign hi         = hi_q;
  assign lo         = lo_q;
`else
  logic unused_mul;

  assign unused_mul = ^{id.mul_op, clk, resetn};
  assign exe_result = alu_result;
  assign EXE_over   = EXE_valid;
  assign hi         = 32'd0;
  assign lo         = 32'd0;
`endif

  assign EXE_MEM_bus = {id.mem_control, id.store_data, exe_result,
                        id.rf_wen, id.rf_wdest, id.pc};
  assign EXE_pc      = id.pc;

endmodule

// File: tb/tb_exe_iter.sv
// Self-checking bench for exe_iter: table-driven ALU vectors with a scoreboard,
// plus multiply, abort and reset sequences when EXE_MULT_EN is defined.
module tb_exe_iter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EXE_valid;
  logic [143:0] bus;
  logic         EXE_over;
  logic [105:0] EXE_MEM_bus;
  logic [31:0]  EXE_pc, hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  logic [105:0] exp_q[$];
  logic [63:0]  mul_q[$];

  typedef struct {
    logic [1:0]  mo;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[18];

  exe_iter dut (
    .clk          (clk),
    .resetn       (resetn),
    .EXE_valid    (EXE_valid),
    .ID_EXE_bus_r (bus),
    .EXE_over     (EXE_over),
    .EXE_MEM_bus  (EXE_MEM_bus),
    .EXE_pc       (EXE_pc),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [143:0] mk(input logic [1:0] mo, input logic [3:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] mc, input logic [31:0] sd,
                                      input logic wen, input logic [4:0] wd,
                                      input logic [31:0] pc);
    return {mo, op, a, b, mc, sd, wen, wd, pc};
  endfunction

  task automatic run_mul(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input string nm);
    logic [63:0] e;
    logic        bad;
    bad = 1'b0;
    @(posedge clk); #1;
    bus = mk({1'b1, sg}, 4'h0, a, b, 4'h3, 32'hCAFE0000, 1'b1, 5'd9, 32'h0000_0400);
    EXE_valid = 1'b1;
    mul_q.push_back(prod);
    for (int c = 0; c <= 33; c++) begin
      if (c == 5) begin
        bus[137:106] = ~a;
        bus[105:74]  = b + 32'd1;
      end
      @(negedge clk);
      if (EXE_over !== (c == 33)) bad = 1'b1;
      if (c == 33) begin
        if (mul_q.size() == 0) begin
          chk({nm, "_queue"}, 0, 1);
        end else begin
          e = mul_q.pop_front();
          chk({nm, "_result"}, EXE_MEM_bus[69:38], e[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    chk({nm, "_over_timing"}, bad, 0);
    EXE_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_hi"}, hi, prod[63:32]);
    chk({nm, "_lo"}, lo, prod[31:0]);
  endtask

  initial begin
    logic [31:0]  sd, pc;
    logic [3:0]   mc;
    logic [4:0]   wd;
    logic         wen;
    logic [105:0] eb;
    logic         bad;

    vecs[0]  = '{2'b00, 4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{2'b00, 4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b00, 4'h2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{2'b00, 4'h3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4]  = '{2'b00, 4'h2, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[5]  = '{2'b00, 4'h3, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[6]  = '{2'b00, 4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[7]  = '{2'b01, 4'h5, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
    vecs[8]  = '{2'b00, 4'h6, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[9]  = '{2'b00, 4'h7, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987};
    vecs[10] = '{2'b00, 4'h8, 32'h0000_0004, 32'h0000_000F, 32'h0000_00F0};
    vecs[11] = '{2'b00, 4'h8, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010};
    vecs[12] = '{2'b00, 4'h9, 32'h0000_0004, 32'hF000_0000, 32'h0F00_0000};
    vecs[13] = '{2'b00, 4'hA, 32'h0000_0004, 32'hF000_0000, 32'hFF00_0000};
    vecs[14] = '{2'b00, 4'hB, 32'h5555_5555, 32'h1234_ABCD, 32'hABCD_0000};
    vecs[15] = '{2'b00, 4'hC, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};
    vecs[16] = '{2'b01, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[17] = '{2'b00, 4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};

    resetn    = 1'b0;
    EXE_valid = 1'b0;
    bus       = '0;
    @(negedge clk);
    chk("reset_over", EXE_over, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      sd  = $urandom;
      pc  = $urandom;
      mc  = 4'(i);
      wd  = 5'(i + 3);
      wen = 1'(i & 1);
      bus = mk(vecs[i].mo, vecs[i].op, vecs[i].a, vecs[i].b, mc, sd, wen, wd, pc);
      EXE_valid = 1'b1;
      exp_q.push_back({mc, sd, vecs[i].res, wen, wd, pc});
      @(negedge clk);
      chk($sformatf("alu_over_%0d", i), EXE_over, 1);
      chk($sformatf("alu_pc_%0d", i), EXE_pc, pc);
      if (exp_q.size() == 0) begin
        chk($sformatf("alu_queue_%0d", i), 0, 1);
      end else begin
        eb = exp_q.pop_front();
        chk($sformatf("alu_bus_%0d", i), EXE_MEM_bus, eb);
      end
    end

    @(posedge clk); #1;
    EXE_valid = 1'b0;
    @(negedge clk);
    chk("idle_over", EXE_over, 0);
    chk("alu_hi", hi, 0);
    chk("alu_lo", lo, 0);

`ifdef EXE_MULT_EN
    run_mul(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, "mul_s_neg2x3");
    run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mul_u_max");
    run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mul_s_min");

    // abort: valid drops in cycle 10
    bad = 1'b0;
    @(posedge clk); #1;
    bus = mk(2'b10, 4'h0, 32'd5, 32'd7, 4'h0, 32'd0, 1'b1, 5'd2, 32'h0000_0800);
    EXE_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (EXE_over !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    EXE_valid = 1'b0;
    for (int c = 10; c < 45; c++) begin
      @(negedge clk);
      if (EXE_over !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_over", bad, 0);
    chk("abort_hi", hi, 32'h4000_0000);
    chk("abort_lo", lo, 32'h0000_0000);
    bus = mk(2'b00, 4'h0, 32'd10, 32'd20, 4'h1, 32'd0, 1'b1, 5'd4, 32'h0000_0900);
    EXE_valid = 1'b1;
    @(negedge clk);
    chk("abort_add_over", EXE_over, 1);
    chk("abort_add_result", EXE_MEM_bus[69:38], 32'd30);

    // reset in cycle 20 of a multiply
    @(posedge clk); #1;
    EXE_valid = 1'b0;
    @(posedge clk); #1;
    bus = mk(2'b10, 4'h0, 32'd9, 32'd9, 4'h0, 32'd0, 1'b1, 5'd2, 32'h0000_0A00);
    EXE_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_over", EXE_over, 0);
    @(posedge clk); #1;
    EXE_valid = 1'b0;
    resetn    = 1'b1;
    run_mul(1'b0, 32'd5, 32'd7, 64'd35, "mul_after_rst");
`else
    // without the multiplier, mult instructions execute as plain ALU ops
    @(posedge clk); #1;
    bus = mk(2'b11, 4'h0, 32'd2, 32'd3, 4'h2, 32'd0, 1'b1, 5'd1, 32'h0000_0100);
    EXE_valid = 1'b1;
    @(negedge clk);
    chk("nomul_over", EXE_over, 1);
    chk("nomul_result", EXE_MEM_bus[69:38], 32'd5);
    for (int c = 0; c < 40; c++) @(posedge clk);
    #1;
    @(negedge clk);
    chk("nomul_over_held", EXE_over, 1);
    chk("nomul_hi", hi, 0);
    chk("nomul_lo", lo, 0);
    bad = 1'b0;
    chk("nomul_bad", bad, 0);
    EXE_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
